// File: rtl/part4_subtraction.sv
// Multi-cycle IEEE-754 single-precision subtractor (i1 - i2) with valid/ready handshakes.
// Truncating alignment, flush-to-zero on denormals, NaN output on any exponent-255 operand.
module part4_subtraction (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diffAll
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_signX;
  logic        r_signY;
  logic [7:0]  r_expX;
  logic [23:0] r_manX;
  logic [23:0] r_manY;
  logic [7:0]  r_d;
  logic [24:0] r_res;
  logic [31:0] r_diff;

  logic        w_accept;
  logic        w_special;
  logic        w_swap;
  logic [31:0] w_b;
  logic [31:0] w_x;
  logic [31:0] w_y;

  // Subtraction is addition of the negated subtrahend; the larger magnitude becomes X.
  assign w_b       = {~i2[31], i2[30:0]};
  assign w_swap    = w_b[30:0] > i1[30:0];
  assign w_x       = w_swap ? w_b : i1;
  assign w_y       = w_swap ? i1  : w_b;
  assign w_special = (i1[30:23] == 8'hFF) || (i2[30:23] == 8'hFF);
  assign w_accept  = in_valid && (r_state == IDLE);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diffAll   = r_diff;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_stateNext = w_special ? DONE : ALIGN;
      ALIGN: if ((r_d > 8'd24) || (r_d <= 8'd1)) w_stateNext = ADD;
      ADD:   w_stateNext = NORM;
      NORM:  if ((r_res == 25'd0) || r_res[24] || r_res[23] || (r_expX <= 8'd1))
               w_stateNext = DONE;
      DONE:  if (out_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_signX <= 1'b0;
      r_signY <= 1'b0;
      r_expX  <= 8'd0;
      r_manX  <= 24'd0;
      r_manY  <= 24'd0;
      r_d     <= 8'd0;
      r_res   <= 25'd0;
      r_diff  <= 32'h0000_0000;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_signX <= w_x[31];
          r_signY <= w_y[31];
          r_expX  <= w_x[30:23];
          r_manX  <= (w_x[30:23] == 8'd0) ? 24'd0 : {1'b1, w_x[22:0]};
          r_manY  <= (w_y[30:23] == 8'd0) ? 24'd0 : {1'b1, w_y[22:0]};
          r_d     <= w_x[30:23] - w_y[30:23];
          if (w_special) r_diff <= 32'h7FC0_0000;
        end
        ALIGN: begin
          if (r_d > 8'd24) begin
            r_manY <= 24'd0;
            r_d    <= 8'd0;
          end else if (r_d != 8'd0) begin
            r_manY <= r_manY >> 1;
            r_d    <= r_d - 8'd1;
          end
        end
        ADD: begin
          if (r_signX == r_signY) r_res <= {1'b0, r_manX} + {1'b0, r_manY};
          else                    r_res <= {1'b0, r_manX} - {1'b0, r_manY};
        end
        // Left shifts happen one per cycle; the exponent may never be decremented to zero.
        NORM: begin
          if (r_res == 25'd0) begin
            r_diff <= 32'h0000_0000;
          end else if (r_res[24]) begin
            r_expX <= r_expX + 8'd1;
            if (r_expX == 8'd254) r_diff <= {r_signX, 8'hFF, 23'd0};
            else                  r_diff <= {r_signX, r_expX + 8'd1, r_res[23:1]};
          end else if (r_res[23]) begin
            r_diff <= {r_signX, r_expX, r_res[22:0]};
          end else if (r_expX <= 8'd1) begin
            r_diff <= 32'h0000_0000;
          end else begin
            r_res  <= {r_res[23:0], 1'b0};
            r_expX <= r_expX - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_part4_subtraction.sv
// Self-checking bench for part4_subtraction: directed corner cases plus randomized
// operand pairs compared against an integer-arithmetic reference model.
module tb_part4_subtraction;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] i1;
  logic [31:0] i2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diffAll;

  int errors = 0;
  int checks = 0;

  part4_subtraction dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i1        (i1),
    .i2        (i2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diffAll   (diffAll)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference: align by truncating right shift, integer add/subtract, then normalize.
  function automatic logic [31:0] refSub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nb, x, y;
    longint      mx, my, s;
    int          ex, ey, d, e;
    nb = {~b[31], b[30:0]};
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
    if (nb[30:0] > a[30:0]) begin x = nb; y = a; end
    else                    begin x = a;  y = nb; end
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 64'sd0 : longint'({1'b1, x[22:0]});
    my = (ey == 0) ? 64'sd0 : longint'({1'b1, y[22:0]});
    d  = ex - ey;
    my = (d > 24) ? 64'sd0 : (my >> d);
    s  = (x[31] == y[31]) ? mx + my : mx - my;
    if (s == 0) return 32'h00000000;
    e = ex;
    if (s >= 64'sd16777216) begin
      s = s >> 1;
      e = e + 1;
      if (e == 255) return {x[31], 8'hFF, 23'd0};
    end
    while (s < 64'sd8388608) begin
      if (e == 1) return 32'h00000000;
      s = s << 1;
      e = e - 1;
    end
    return {x[31], e[7:0], s[22:0]};
  endfunction

  task automatic genPair(output logic [31:0] a, output logic [31:0] b);
    int mode, ea, eb;
    logic [31:0] ma, mb;
    mode = int'($urandom_range(0, 19));
    ea   = int'($urandom_range(1, 254));
    eb   = ea + int'($urandom_range(0, 60)) - 30;
    if (eb < 1)   eb = 1;
    if (eb > 254) eb = 254;
    if (mode == 0) ea = 0;
    if (mode == 1) eb = 0;
    if (mode == 2) eb = 255;
    if (mode == 3) begin ea = int'($urandom_range(250, 254)); eb = ea; end
    if (mode == 4) begin ea = int'($urandom_range(1, 3)); eb = ea; end
    if (mode == 5) eb = ea;
    ma = $urandom;
    mb = (mode == 4 || mode == 5) ? (ma ^ 32'($urandom_range(0, 255))) : $urandom;
    a  = {1'($urandom), ea[7:0], ma[22:0]};
    b  = {1'($urandom), eb[7:0], mb[22:0]};
  endtask

  // One transaction: accept, wait for the result, optional backpressure, then release.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expected, input int hold, output int lat);
    int cyc;
    checkOutput({tag, "_inReady"}, 32'(in_ready), 32'd1);
    i1 = a;
    i2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    i1 = $urandom;
    i2 = $urandom;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) checkOutput({tag, "_timeout"}, 32'(cyc), 32'd0);
    checkOutput(tag, diffAll, expected);
    checkOutput({tag, "_latMax"}, 32'(cyc <= 50), 32'd1);
    lat = cyc;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      i1 = $urandom;
      i2 = $urandom;
      @(posedge clk); #1;
      checkOutput({tag, "_holdValid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_holdInReady"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_holdData"}, diffAll, expected);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] a, b;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    i1 = 32'd0;
    i2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstDiff", diffAll, 32'h00000000);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("sub3m1", 32'h40400000, 32'h3F800000, 32'h40000000, 0, lat);
    checkOutput("lat3m1", 32'(lat), 32'd4);
    applyStimulus("sub15m125", 32'h3FC00000, 32'h3FA00000, 32'h3E800000, 0, lat);
    checkOutput("lat15m125", 32'(lat), 32'd6);
    applyStimulus("subEqual", 32'h3F800000, 32'h3F800000, 32'h00000000, 0, lat);
    applyStimulus("subCarry", 32'h3F800000, 32'hBF800000, 32'h40000000, 0, lat);
    checkOutput("latCarry", 32'(lat), 32'd4);
    applyStimulus("subFar", 32'h3F800000, 32'h30800000, 32'h3F800000, 0, lat);
    checkOutput("latFar", 32'(lat), 32'd4);
    applyStimulus("subInfIn", 32'h7F800000, $urandom, 32'h7FC00000, 0, lat);
    checkOutput("latSpecial", 32'(lat), 32'd1);
    applyStimulus("subOverflow", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 0, lat);
    applyStimulus("subUnderflow", 32'h00800001, 32'h00800000, 32'h00000000, 0, lat);
    applyStimulus("backpressure", 32'h40400000, 32'h3F800000, 32'h40000000, 5, lat);
    applyStimulus("afterBp", 32'h3FC00000, 32'h3FA00000, 32'h3E800000, 0, lat);

    // Reset in the middle of a long alignment (exponent difference 20).
    i1 = 32'h3F800000;
    i2 = 32'h35800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstInReady", 32'(in_ready), 32'd1);
    checkOutput("midRstDiff", diffAll, 32'h00000000);
    applyStimulus("postRst3m1", 32'h40400000, 32'h3F800000, 32'h40000000, 0, lat);

    for (int n = 0; n < 250; n++) begin
      genPair(a, b);
      applyStimulus("rand", a, b, refSub(a, b), int'($urandom_range(0, 2)), lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
